// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants for the instruction loader and the datapath controller.
// Op-class enum, opcode/funct map, loader FSM states and small field-packing helpers.
package instr_pkg;

  // Symbolic op classes offered by the host; 4'hE and 4'hF are undefined (4'hF reserved).
  typedef enum logic [3:0] {
    OP_ADD     = 4'h0,
    OP_SUB     = 4'h1,
    OP_AND     = 4'h2,
    OP_OR      = 4'h3,
    OP_SLT     = 4'h4,
    OP_JR      = 4'h5,
    OP_J       = 4'h6,
    OP_JAL     = 4'h7,
    OP_LW      = 4'h8,
    OP_SW      = 4'h9,
    OP_BEQ     = 4'hA,
    OP_BNE     = 4'hB,
    OP_ORI     = 4'hC,
    OP_ADDI    = 4'hD,
    OP_ILLEGAL = 4'hF
  } op_e;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Loader FSM states; StCheck is only reachable with readback enabled.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StDrain = 3'd2,
    StDone  = 3'd3,
    StCheck = 3'd4
  } ld_state_e;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/instr_word_encode.sv
// Combinational MIPS word builder: op class plus fields in, 32-bit word and illegal flag out.
module instr_word_encode
  import instr_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Map op class to its encoding; anything outside the defined set is flagged illegal.
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (op_e'(i_op))
      OP_ADD:  o_word = enc_r(i_rs, i_rt, i_rd, FUNCT_ADD);
      OP_SUB:  o_word = enc_r(i_rs, i_rt, i_rd, FUNCT_SUB);
      OP_AND:  o_word = enc_r(i_rs, i_rt, i_rd, FUNCT_AND);
      OP_OR:   o_word = enc_r(i_rs, i_rt, i_rd, FUNCT_OR);
      OP_SLT:  o_word = enc_r(i_rs, i_rt, i_rd, FUNCT_SLT);
      OP_JR:   o_word = enc_r(i_rs, 5'd0, 5'd0, FUNCT_JR);
      OP_J:    o_word = enc_j(OPC_J, i_target);
      OP_JAL:  o_word = enc_j(OPC_JAL, i_target);
      OP_LW:   o_word = enc_i(OPC_LW, i_rs, i_rt, i_imm);
      OP_SW:   o_word = enc_i(OPC_SW, i_rs, i_rt, i_imm);
      OP_BEQ:  o_word = enc_i(OPC_BEQ, i_rs, i_rt, i_imm);
      OP_BNE:  o_word = enc_i(OPC_BNE, i_rs, i_rt, i_imm);
      OP_ORI:  o_word = enc_i(OPC_ORI, i_rs, i_rt, i_imm);
      OP_ADDI: o_word = enc_i(OPC_ADDI, i_rs, i_rt, i_imm);
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder and IMEM loader: one symbolic instruction per handshake,
// written to consecutive word addresses from a session base address.
// Optional readback verification after every write: define INSTR_LOADER_READBACK_EN.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic                           load_end,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [3:0]                     in_op,
  input  logic [4:0]                     in_rs,
  input  logic [4:0]                     in_rt,
  input  logic [4:0]                     in_rd,
  input  logic [15:0]                    in_imm,
  input  logic [25:0]                    in_target,
  output logic                           imem_we,
  output logic [ADDR_W-1:0]              imem_addr,
  output logic [31:0]                    imem_wdata,
  input  logic [31:0]                    imem_rdata,
  output logic [$clog2(MAX_WORDS):0]     word_count,
  output logic                           full,
  output logic                           done,
  output logic                           err_illegal,
  output logic                           err_readback
);

  localparam int unsigned CntW = $clog2(MAX_WORDS) + 1;

  ld_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_accept;
  logic              w_unused;

  instr_word_encode u_encode (
    .i_op      (in_op),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign full     = (word_count == CntW'(MAX_WORDS));
  assign w_accept = in_valid & in_ready;

`ifdef INSTR_LOADER_READBACK_EN
  logic r_cmp_pend;  // imem_rdata this cycle holds the word just written
  logic r_end_seen;  // load_end arrived while a write/check was still in flight

  // No new accept while a write or its check is in flight.
  assign in_ready = (r_state == StLoad) && !full && !imem_we && !r_end_seen;
  assign w_unused = ^{base_addr[1:0]};
`else
  assign in_ready     = (r_state == StLoad) && !full;
  assign err_readback = 1'b0;
  assign w_unused     = ^{base_addr[1:0], imem_rdata};
`endif

  // Session FSM, address counter and registered IMEM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      word_count  <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
`ifdef INSTR_LOADER_READBACK_EN
      err_readback <= 1'b0;
      r_cmp_pend   <= 1'b0;
      r_end_seen   <= 1'b0;
`endif
    end else begin
`ifdef INSTR_LOADER_READBACK_EN
      if (r_cmp_pend) begin
        r_cmp_pend <= 1'b0;
        if (imem_rdata != imem_wdata) err_readback <= 1'b1;
      end
`endif
      case (r_state)
        StIdle, StDone: begin
          imem_we <= 1'b0;
          if (load_start) begin
            r_state     <= StLoad;
            r_addr      <= {base_addr[ADDR_W-1:2], 2'b00};
            word_count  <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
`ifdef INSTR_LOADER_READBACK_EN
            err_readback <= 1'b0;
            r_end_seen   <= 1'b0;
`endif
          end
        end
        StLoad: begin
`ifdef INSTR_LOADER_READBACK_EN
          if (imem_we) begin
            // Write cycle: hold the address and read it back next.
            imem_we <= 1'b0;
            r_state <= StCheck;
            if (load_end) r_end_seen <= 1'b1;
          end else
`endif
          begin
            imem_we <= 1'b0;
            if (w_accept) begin
              if (w_illegal) begin
                err_illegal <= 1'b1;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= r_addr;
                imem_wdata <= w_word;
                r_addr     <= r_addr + ADDR_W'(4);
                word_count <= word_count + CntW'(1);
              end
            end
            if (load_end) begin
              if (w_accept && !w_illegal) begin
`ifdef INSTR_LOADER_READBACK_EN
                r_end_seen <= 1'b1;
`else
                r_state <= StDrain;
`endif
              end else begin
                r_state <= StDone;
                done    <= 1'b1;
              end
            end
          end
        end
`ifdef INSTR_LOADER_READBACK_EN
        StCheck: begin
          r_cmp_pend <= 1'b1;
          if (r_end_seen || load_end) begin
            r_end_seen <= 1'b1;
            r_state    <= StDrain;
          end else begin
            r_state <= StLoad;
          end
        end
`endif
        StDrain: begin
          imem_we <= 1'b0;
          r_state <= StDone;
          done    <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (MAX_WORDS = 4) with a write scoreboard
// and a synchronous IMEM model that corrupts bit 0 of the word stored at 0x44.
module tb_instr_encoder_loader;
  import instr_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_end, in_valid, in_ready;
  logic [31:0] base_addr;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;
  logic [2:0]  word_count;
  logic        full, done, err_illegal, err_readback;

  wr_t         sb_q[$];
  wr_t         m_exp;
  logic [31:0] exp_addr;
  logic [31:0] mem [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          last_stall;

  instr_encoder_loader #(
    .ADDR_W    (32),
    .MAX_WORDS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .base_addr    (base_addr),
    .load_end     (load_end),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_imm       (in_imm),
    .in_target    (in_target),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_rdata   (imem_rdata),
    .word_count   (word_count),
    .full         (full),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_readback (err_readback)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder with literal opcode/funct values.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [15:0] imm, input logic [25:0] tgt,
                                        output bit legal);
    legal = 1'b1;
    case (op)
      4'h0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'h1: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'h2: return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'h3: return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'h4: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'h5: return {6'h00, rs, 15'd0, 6'h08};
      4'h6: return {6'h02, tgt};
      4'h7: return {6'h03, tgt};
      4'h8: return {6'h23, rs, rt, imm};
      4'h9: return {6'h2B, rs, rt, imm};
      4'hA: return {6'h04, rs, rt, imm};
      4'hB: return {6'h05, rs, rt, imm};
      4'hC: return {6'h0D, rs, rt, imm};
      4'hD: return {6'h08, rs, rt, imm};
      default: begin
        legal = 1'b0;
        return 32'h0;
      end
    endcase
  endfunction

  // IMEM model: synchronous read, bit 0 flipped on store to 0x44.
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr[11:2]] <= imem_wdata ^ 32'(imem_addr == 32'h44);
    imem_rdata <= mem[imem_addr[11:2]];
  end

  // Scoreboard consumer: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      check_eq("write_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        m_exp = sb_q.pop_front();
        check_eq("wr_addr", imem_addr, m_exp.addr);
        check_eq("wr_data", imem_wdata, m_exp.word);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit last);
    bit          legal;
    logic [31:0] w;
    int          c;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    c = 0;
    while (!in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    last_stall = c;
    if (!in_ready) begin
      check_eq("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    load_end = last;
    w = model(op, rs, rt, rd, imm, tgt, legal);
    if (legal) begin
      sb_q.push_back('{addr: exp_addr, word: w});
      exp_addr = exp_addr + 32'd4;
    end
    @(negedge clk);
    in_valid = 1'b0;
    load_end = 1'b0;
  endtask

  task automatic start(input logic [31:0] base);
    base_addr  = base;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    exp_addr   = {base[31:2], 2'b00};
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 10) begin
      @(negedge clk);
      c++;
    end
    check_eq("done", 64'(done), 64'd1);
  endtask

  task automatic end_session();
    load_end = 1'b1;
    @(negedge clk);
    load_end = 1'b0;
    wait_done();
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_end = 1'b0; in_valid = 1'b0; base_addr = '0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs",
             64'({in_ready, imem_we, imem_addr, imem_wdata[27:0], word_count, full, done,
                  err_illegal, err_readback}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single ADD at 0x40
    start(32'h0000_0040);
    check_eq("start_count", 64'(word_count), 64'd0);
    check_eq("start_ready", 64'(in_ready), 64'd1);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    check_eq("add_we", 64'(imem_we), 64'd1);
    check_eq("add_count", 64'(word_count), 64'd1);
    end_session();

    // Back-to-back LW, JR, J; load_end with the last accept
    start(32'h0000_0040);
    check_eq("restart_done_clr", 64'(done), 64'd0);
    send(OP_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0);
    send(OP_JR, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
`ifdef INSTR_LOADER_READBACK_EN
    check_eq("rb_ready_low_cycles", 64'(last_stall), 64'd2);
`else
    check_eq("b2b_no_stall", 64'(last_stall), 64'd0);
`endif
    send(OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
    wait_done();
    check_eq("b2b_count", 64'(word_count), 64'd3);
`ifdef INSTR_LOADER_READBACK_EN
    check_eq("err_readback", 64'(err_readback), 64'd1);
`else
    check_eq("err_readback", 64'(err_readback), 64'd0);
`endif

    // Fill to MAX_WORDS, then stall further offers
    start(32'h0000_0301);
    send(OP_ADDI, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    send(OP_ORI, 5'd6, 5'd7, 5'd0, 16'h1234, 26'h0, 1'b0);
    send(OP_BEQ, 5'd8, 5'd9, 5'd0, 16'h8000, 26'h0, 1'b0);
    send(OP_SW, 5'd10, 5'd11, 5'd0, 16'h0010, 26'h0, 1'b0);
    check_eq("full_set", 64'(full), 64'd1);
    check_eq("full_ready", 64'(in_ready), 64'd0);
    in_op = OP_SLT; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_op = OP_AND;
    repeat (2) @(negedge clk);
    check_eq("full_stall_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    end_session();
    check_eq("full_count", 64'(word_count), 64'd4);

    // Illegal op between two legal ops
    start(32'h0000_0200);
    send(OP_ADD, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
    send(4'hF, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0);
    send(OP_SUB, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0, 1'b0);
    check_eq("illegal_flag", 64'(err_illegal), 64'd1);
    check_eq("illegal_count", 64'(word_count), 64'd2);
    end_session();

    // Reset right after an accept discards the pending write
    start(32'h0000_0100);
    in_op = OP_ADD; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("rst_async_we", 64'(imem_we), 64'd0);
    @(negedge clk);
    check_eq("rst_outputs",
             64'({in_ready, imem_we, imem_addr, imem_wdata[27:0], word_count, full, done,
                  err_illegal, err_readback}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    start(32'h0000_0104);
    send(OP_OR, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b0);
    end_session();
    check_eq("post_rst_count", 64'(word_count), 64'd1);

    // Address wrap at top of the space; base bits [1:0] ignored
    start(32'hFFFF_FFFE);
    send(OP_ADDI, 5'd1, 5'd2, 5'd0, 16'h0042, 26'h0, 1'b0);
    send(OP_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b0);
    end_session();

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Sequential MIPS instruction encoder and instruction-memory loader for the single-cycle datapath test environment. It accepts one symbolic instruction per handshake (op class plus fields), builds the 32-bit MIPS word using the same opcode/funct map the datapath controller decodes, and writes the word into instruction memory at consecutive word addresses. It sits between a bench/host stimulus source and the IMEM write port, and runs before the core is released from reset.

Parameters:
ADDR_W, 32, width of the IMEM byte address
MAX_WORDS, 256, maximum number of words written per load session

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
load_start  in  1  one-cycle pulse; opens a session at base_addr
base_addr  in  ADDR_W  first byte address; bits [1:0] ignored, forced to 0
load_end  in  1  one-cycle pulse; closes the session
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept
in_op  in  4  op class, enum from package
in_rs, in_rt, in_rd  in  5 each  register fields
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target
imem_we  out  1  IMEM write strobe
imem_addr  out  ADDR_W  IMEM byte address, read or write
imem_wdata  out  32  encoded word
imem_rdata  in  32  synchronous IMEM read data, valid one cycle after address; used only with READBACK_EN
word_count  out  $clog2(MAX_WORDS)+1  words written this session
full  out  1  word_count == MAX_WORDS
done  out  1  session closed, all writes retired
err_illegal  out  1  sticky; an undefined op was offered
err_readback  out  1  sticky; readback mismatch (0 when READBACK_EN is off)

Behaviour:
- Reset: state IDLE. All outputs 0: in_ready, imem_we, imem_addr, imem_wdata, word_count, full, done, err_*.
- FSM states: IDLE, LOAD, DRAIN, DONE (plus CHECK with READBACK_EN).
  - IDLE/DONE --load_start--> LOAD. This clears word_count, done, err_*, and sets addr = {base_addr[ADDR_W-1:2],2'b00}.
  - load_start is ignored in LOAD, DRAIN and CHECK.
  - LOAD --load_end--> DRAIN if a write is pending, else DONE.
  - DRAIN --write retired--> DONE.
- in_ready = (state == LOAD) && !full && !load_end_seen.
- Accept = in_valid & in_ready. The encoded word is registered on accept. On the next cycle imem_we=1 with imem_addr=addr and imem_wdata=word. After that write, addr += 4 and word_count += 1. Latency accept→write is 1 cycle, throughput is 1 word/cycle.
- Encoding:
  - R-type {6'h00, rs, rt, rd, 5'b0, funct}: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - JR {6'h00, rs, 15'b0, 001000}.
  - J {000010, target}, JAL {000011, target}.
  - I-type {opc, rs, rt, imm}: LW 100011, SW 101011, BEQ 000100, BNE 000101, ORI 001101, ADDI 001000.
- Undefined in_op: the handshake completes, no write is issued, err_illegal is set, word_count is unchanged.
- Full: when word_count reaches MAX_WORDS, in_ready drops. Further in_valid stalls until load_end arrives.
- load_end in the same cycle as an accept: the word is accepted and written, then the block goes to DONE.
- Address wrap: addr wraps modulo 2^ADDR_W with no flag.
- done = 1 only in DONE. Held until the next load_start.
- rst asserted mid-session: immediate return to IDLE. A pending write is discarded, and imem_we deasserts asynchronously.

Optional Feature:
Macro: INSTR_LOADER_READBACK_EN
- Defined:
  - After each write, the FSM enters CHECK. In CHECK, imem_addr holds the written address with imem_we=0.
  - On the following cycle, imem_rdata is compared with the written word. A mismatch sets err_readback.
  - in_ready is low during CHECK, so throughput drops to 1 word per 3 cycles.
- Undefined: no CHECK state, imem_rdata unused, err_readback tied 0.

Decomposition:
- Shared package instr_pkg holds:
  - op-class enum (OP_ADD…OP_ADDI, 4-bit), with 4'hF reserved as illegal;
  - OPC_* and FUNCT_* 6-bit constants, shared with the datapath controller so encoder and decoder cannot diverge.
- Natural sub-module: instr_word_encode, purely combinational (op + fields → word, illegal flag). The FSM, address counter and write register stay in instr_encoder_loader.

Test Plan:
- load_start with base 0x0000_0040, then ADD rd=3 rs=1 rt=2 → 1 cycle later imem_we=1, addr 0x40, wdata 0x00221820, word_count=1.
- Back-to-back LW rt=8 rs=29 imm=4, JR rs=31, J target=0x10 → writes 0x8FA80004 @0x40, 0x03E00008 @0x44, 0x08000010 @0x48 on consecutive cycles.
- MAX_WORDS=4, offer 6 instructions → 4 writes, full=1, in_ready=0; load_end → done=1, word_count=4.
- in_op=4'hF between two valid ops → no write for it, err_illegal=1, addresses of the valid ops are contiguous.
- rst asserted the cycle after an accept → no write issued, all outputs 0. A new session then starts cleanly at its base_addr.
- READBACK_EN with the memory model corrupting bit 0 at address 0x44 → err_readback=1; in_ready is low 2 cycles after each write.
